mem_dm_port: RTL and testbench

//  MEM-stage data-memory responder; consumes the EX/MEM bundle (MemWrite, dm_ctrl, wea, aluout,
//  dm_Data_out, RegWrite, rd, WDSel, WD) and completes loads/stores over a req/ack data-memory bus.

---
 rtl/mem_dm_port.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_dm_port.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dm_port.sv
// -----------------------------------------------------------------------------
// mem_dm_port
// MEM-stage data-memory responder. Takes the EX/MEM bundle, runs loads and
// stores over a req/ack data-memory bus, lane-shifts store data and byte
// enables, extracts and sign/zero-extends load data, and registers the
// MEM/WB bundle. While a bus transaction is outstanding, stall_o holds the
// upstream stages and keeps the EX/MEM inputs stable.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   : a misaligned word/halfword access issues no bus request and
//               pulses misalign_o instead.
//   undefined : the low address bits are truncated to natural alignment and
//               the access proceeds normally.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   mem_write_i       store request (wins over mem_read_i)
//   mem_read_i        load request
//   dm_ctrl_i [2:0]   access size / signedness
//   wea_i [3:0]       unshifted store byte enables
//   aluout_i [31:0]   effective byte address
//   st_data_i [31:0]  unshifted store data
//   reg_write_in_i, rd_in_i[4:0], wdsel_in_i[1:0], wd_in_i[31:0]  EX/MEM wb fields
//   dm_req_o, dm_we_o, dm_addr_o[29:0], dm_be_o[3:0], dm_wdata_o[31:0]  bus request
//   dm_ack_i, dm_rdata_i[31:0]  bus completion pulse and read data
//   stall_o           hold upstream while a transaction is pending
//   bus_err_o         one-cycle pulse on timeout abort
//   wb_reg_write_o, wb_rd_o[4:0], wb_wdsel_o[1:0], wb_wd_o[31:0]  MEM/WB bundle
//   misalign_o        (MEM_MISALIGN_TRAP_EN only) one-cycle misalign pulse
// -----------------------------------------------------------------------------
module mem_dm_port #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  input  logic [2:0]  dm_ctrl_i,
  input  logic [3:0]  wea_i,
  input  logic [31:0] aluout_i,
  input  logic [31:0] st_data_i,
  input  logic        reg_write_in_i,
  input  logic [4:0]  rd_in_i,
  input  logic [1:0]  wdsel_in_i,
  input  logic [31:0] wd_in_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [29:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i,
  output logic        stall_o,
  output logic        bus_err_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_rd_o,
  output logic [1:0]  wb_wdsel_o,
  output logic [31:0] wb_wd_o
);

  localparam logic [2:0] DM_WORD     = 3'd0;
  localparam logic [2:0] DM_HALF     = 3'd1;
  localparam logic [2:0] DM_HALF_U   = 3'd2;
  localparam logic [2:0] DM_BYTE     = 3'd3;
  localparam logic [2:0] DM_BYTE_U   = 3'd4;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        dm_req_q, dm_we_q, bus_err_q;
  logic [29:0] dm_addr_q;
  logic [3:0]  dm_be_q;
  logic [31:0] dm_wdata_q;
  logic        wb_reg_write_q;
  logic [4:0]  wb_rd_q;
  logic [1:0]  wb_wdsel_q;
  logic [31:0] wb_wd_q;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_q;
  logic        misalign_s;
`endif

  logic        access_s;
  logic        is_load_s;
  logic [1:0]  off_s;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted_s;
  logic [31:0] ld_data_d;

  // Decode access type; a store takes priority over a simultaneous load.
  always_comb begin
    access_s  = mem_read_i | mem_write_i;
    is_load_s = mem_read_i & ~mem_write_i;
  end

  // Lane offset: words are forced to lane 0, halfwords use bit 1 only,
  // which is what truncates a misaligned address to natural alignment.
  always_comb begin
    off_s = 2'b00;
    case (dm_ctrl_i)
      DM_WORD:              off_s = 2'b00;
      DM_HALF, DM_HALF_U:   off_s = {aluout_i[1], 1'b0};
      DM_BYTE, DM_BYTE_U:   off_s = aluout_i[1:0];
      default:              off_s = 2'b00;
    endcase
  end

  // Store lane shifting; loads present no byte enables on the bus.
  always_comb begin
    wdata_d = st_data_i << {off_s, 3'b000};
    if (mem_write_i) begin
      be_d = wea_i << off_s;
    end else begin
      be_d = 4'b0000;
    end
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = dm_rdata_i >> {off_s, 3'b000};
    ld_data_d = shifted_s;
    case (dm_ctrl_i)
      DM_WORD:   ld_data_d = shifted_s;
      DM_HALF:   ld_data_d = {{16{shifted_s[15]}}, shifted_s[15:0]};
      DM_HALF_U: ld_data_d = {16'h0000, shifted_s[15:0]};
      DM_BYTE:   ld_data_d = {{24{shifted_s[7]}}, shifted_s[7:0]};
      DM_BYTE_U: ld_data_d = {24'h000000, shifted_s[7:0]};
      default:   ld_data_d = shifted_s;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misalignment is judged on the raw address, before lane truncation.
  always_comb begin
    misalign_s = 1'b0;
    case (dm_ctrl_i)
      DM_WORD:            misalign_s = (aluout_i[1:0] != 2'b00);
      DM_HALF, DM_HALF_U: misalign_s = aluout_i[0];
      default:            misalign_s = 1'b0;
    endcase
  end
`endif

  // Transaction FSM with all bus and MEM/WB outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      dm_req_q       <= 1'b0;
      dm_we_q        <= 1'b0;
      dm_addr_q      <= 30'd0;
      dm_be_q        <= 4'd0;
      dm_wdata_q     <= 32'd0;
      bus_err_q      <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_wdsel_q     <= 2'd0;
      wb_wd_q        <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q     <= 1'b0;
`endif
    end else begin
      bus_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!access_s) begin
            wb_reg_write_q <= reg_write_in_i;
            wb_rd_q        <= rd_in_i;
            wb_wdsel_q     <= wdsel_in_i;
            wb_wd_q        <= wd_in_i;
`ifdef MEM_MISALIGN_TRAP_EN
          end else if (misalign_s) begin
            misalign_q     <= 1'b1;
            wb_reg_write_q <= 1'b0;
`endif
          end else begin
            dm_req_q       <= 1'b1;
            dm_we_q        <= mem_write_i;
            dm_addr_q      <= aluout_i[31:2];
            dm_be_q        <= be_d;
            dm_wdata_q     <= wdata_d;
            wb_reg_write_q <= 1'b0;
            cnt_q          <= '0;
            state_q        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dm_ack_i) begin
            dm_req_q       <= 1'b0;
            wb_reg_write_q <= reg_write_in_i;
            wb_rd_q        <= rd_in_i;
            wb_wdsel_q     <= wdsel_in_i;
            wb_wd_q        <= is_load_s ? ld_data_d : wd_in_i;
            state_q        <= S_IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            dm_req_q       <= 1'b0;
            bus_err_q      <= 1'b1;
            wb_reg_write_q <= 1'b0;
            state_q        <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          dm_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the upstream hold takes effect in the very
  // cycle an access is first seen; reset forces it low immediately.
  always_comb begin
    if (rst) begin
      stall_o = 1'b0;
    end else if (state_q == S_WAIT) begin
      stall_o = ~dm_ack_i;
    end else begin
      stall_o = access_s;
    end
  end

  assign dm_req_o       = dm_req_q;
  assign dm_we_o        = dm_we_q;
  assign dm_addr_o      = dm_addr_q;
  assign dm_be_o        = dm_be_q;
  assign dm_wdata_o     = dm_wdata_q;
  assign bus_err_o      = bus_err_q;
  assign wb_reg_write_o = wb_reg_write_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_wdsel_o     = wb_wdsel_q;
  assign wb_wd_o        = wb_wd_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_o     = misalign_q;
`endif

endmodule

// File: tb/tb_mem_dm_port.sv
// -----------------------------------------------------------------------------
// tb_mem_dm_port: directed cases followed by randomized instruction traffic,
// checked against an arithmetic reference of lane placement and extension.
// -----------------------------------------------------------------------------
module tb_mem_dm_port;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write, mem_read;
  logic [2:0]  dm_ctrl;
  logic [3:0]  wea;
  logic [31:0] aluout, st_data;
  logic        reg_write_in;
  logic [4:0]  rd_in;
  logic [1:0]  wdsel_in;
  logic [31:0] wd_in;
  logic        dm_req, dm_we;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall, bus_err;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_wdsel;
  logic [31:0] wb_wd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_dm_port #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_write_i(mem_write), .mem_read_i(mem_read), .dm_ctrl_i(dm_ctrl),
    .wea_i(wea), .aluout_i(aluout), .st_data_i(st_data),
    .reg_write_in_i(reg_write_in), .rd_in_i(rd_in), .wdsel_in_i(wdsel_in), .wd_in_i(wd_in),
    .dm_req_o(dm_req), .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_be_o(dm_be),
    .dm_wdata_o(dm_wdata), .dm_ack_i(dm_ack), .dm_rdata_i(dm_rdata),
    .stall_o(stall), .bus_err_o(bus_err),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o(misalign),
`endif
    .wb_reg_write_o(wb_reg_write), .wb_rd_o(wb_rd), .wb_wdsel_o(wb_wdsel), .wb_wd_o(wb_wd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: byte offset, enables, store data, load value ----
  function automatic int ref_off(input logic [2:0] ctrl, input logic [31:0] a);
    if (ctrl == 3'd0) return 0;
    if (ctrl == 3'd1 || ctrl == 3'd2) return (a % 4) / 2 * 2;
    return a % 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] ctrl, input logic [31:0] a,
                                           input logic [31:0] rdata);
    int nbytes, off;
    logic [31:0] v, mask;
    bit sgn;
    off    = ref_off(ctrl, a);
    nbytes = (ctrl == 3'd0) ? 4 : ((ctrl == 3'd1 || ctrl == 3'd2) ? 2 : 1);
    sgn    = (ctrl == 3'd1 || ctrl == 3'd3);
    v      = rdata / (32'd1 << (8 * off));
    if (nbytes == 4) return v;
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    v    = v & mask;
    if (sgn && v >= (mask + 32'd1) / 2) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] ref_wea(input logic [2:0] ctrl);
    if (ctrl == 3'd0) return 4'b1111;
    if (ctrl == 3'd1 || ctrl == 3'd2) return 4'b0011;
    return 4'b0001;
  endfunction

  // Present a non-memory instruction for one cycle and check its writeback.
  task automatic do_nonmem(input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                           input logic [31:0] wd, input logic stray_ack);
    mem_write = 1'b0; mem_read = 1'b0;
    reg_write_in = rw; rd_in = rd; wdsel_in = ws; wd_in = wd;
    dm_ack = stray_ack; dm_rdata = $urandom;
    #1;
    check_eq("nm_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    check_eq("nm_wb_rw", 32'(wb_reg_write), 32'(rw));
    check_eq("nm_wb_rd", 32'(wb_rd), 32'(rd));
    check_eq("nm_wb_ws", 32'(wb_wdsel), 32'(ws));
    check_eq("nm_wb_wd", wb_wd, wd);
    check_eq("nm_req", 32'(dm_req), 32'd0);
    check_eq("nm_berr", 32'(bus_err), 32'd0);
  endtask

  // Memory instruction; ack arrives after 'd' WAIT cycles without it
  // (d >= TIMEOUT means no ack at all).
  task automatic do_mem(input logic wr, input logic rdq, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] sd, input logic rw,
                        input logic [4:0] rd, input logic [1:0] ws, input logic [31:0] wd,
                        input int d, input logic [31:0] rdata);
    int off;
    logic [31:0] exp_wd;
    bit is_load;
    off     = ref_off(ctrl, a);
    is_load = rdq && !wr;
    mem_write = wr; mem_read = rdq; dm_ctrl = ctrl; wea = ref_wea(ctrl);
    aluout = a; st_data = sd;
    reg_write_in = rw; rd_in = rd; wdsel_in = ws; wd_in = wd;
    dm_ack = 1'b0;
    #1;
    check_eq("m_stall_idle", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check_eq("m_req", 32'(dm_req), 32'd1);
    check_eq("m_we", 32'(dm_we), 32'(wr));
    check_eq("m_addr", 32'(dm_addr), a / 4);
    check_eq("m_be", 32'(dm_be), wr ? ((32'(ref_wea(ctrl)) << off) % 16) : 32'd0);
    if (wr) check_eq("m_wdata", dm_wdata, sd * (32'd1 << (8 * off)));
    check_eq("m_bubble", 32'(wb_reg_write), 32'd0);
    for (int w = 1; w <= TIMEOUT; w++) begin
      if (w == d + 1) begin
        dm_ack = 1'b1; dm_rdata = rdata;
        #1;
        check_eq("m_stall_ack", 32'(stall), 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        exp_wd = is_load ? ref_load(ctrl, a, rdata) : wd;
        check_eq("m_done_req", 32'(dm_req), 32'd0);
        check_eq("m_wb_rw", 32'(wb_reg_write), 32'(rw));
        check_eq("m_wb_rd", 32'(wb_rd), 32'(rd));
        check_eq("m_wb_ws", 32'(wb_wdsel), 32'(ws));
        check_eq("m_wb_wd", wb_wd, exp_wd);
        check_eq("m_berr0", 32'(bus_err), 32'd0);
        return;
      end
      dm_ack = 1'b0; dm_rdata = $urandom;
      #1;
      check_eq("m_stall_wait", 32'(stall), 32'd1);
      @(posedge clk); #1;
      if (w < TIMEOUT) begin
        check_eq("m_hold_req", 32'(dm_req), 32'd1);
        check_eq("m_hold_addr", 32'(dm_addr), a / 4);
        check_eq("m_wait_rw", 32'(wb_reg_write), 32'd0);
      end else begin
        check_eq("to_berr", 32'(bus_err), 32'd1);
        check_eq("to_req", 32'(dm_req), 32'd0);
        check_eq("to_rw", 32'(wb_reg_write), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  c;
    logic        wr, rdq;
    int          d;
    // Reset with a pending load on the inputs: everything must stay low.
    rst = 1'b1; mem_write = 1'b0; mem_read = 1'b1; dm_ctrl = 3'd0; wea = 4'b1111;
    aluout = 32'h100; st_data = 32'h0; reg_write_in = 1'b1; rd_in = 5'd3;
    wdsel_in = 2'd1; wd_in = 32'h55; dm_ack = 1'b0; dm_rdata = 32'h0;
    #12;
    check_eq("rst_req", 32'(dm_req), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_be", 32'(dm_be), 32'd0);
    check_eq("rst_addr", 32'(dm_addr), 32'd0);
    check_eq("rst_wdata", dm_wdata, 32'd0);
    check_eq("rst_berr", 32'(bus_err), 32'd0);
    check_eq("rst_wb", {wb_reg_write, wb_rd, wb_wdsel, 24'(wb_wd)}, 32'd0);
    check_eq("rst_wbwd", wb_wd, 32'd0);
    mem_read = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_nonmem(1'b1, 5'd5, 2'd0, 32'h1234, 1'b0);
    do_mem(1'b1, 1'b0, 3'd3, 32'h102, 32'h000000AB, 1'b0, 5'd0, 2'd0, 32'h0, 0, 32'h0);
    do_mem(1'b0, 1'b1, 3'd3, 32'h103, 32'h0, 1'b1, 5'd7, 2'd1, 32'h0, 2, 32'h80FF_FFFF);
    do_mem(1'b0, 1'b1, 3'd2, 32'h202, 32'h0, 1'b1, 5'd8, 2'd1, 32'h0, 0, 32'h8001_0000);
    do_mem(1'b0, 1'b1, 3'd1, 32'h202, 32'h0, 1'b1, 5'd9, 2'd1, 32'h0, 1, 32'h8001_0000);
    do_mem(1'b0, 1'b1, 3'd0, 32'h305, 32'h0, 1'b1, 5'd10, 2'd1, 32'h0, 0, 32'hCAFE_F00D);
    do_mem(1'b0, 1'b1, 3'd0, 32'h400, 32'h0, 1'b1, 5'd11, 2'd1, 32'h0, TIMEOUT, 32'h0);
    do_nonmem(1'b1, 5'd12, 2'd2, 32'hBEEF, 1'b1);
    do_mem(1'b0, 1'b1, 3'd0, 32'h400, 32'h0, 1'b1, 5'd11, 2'd1, 32'h0, TIMEOUT - 1, 32'h1357_9BDF);

    // Reset in the middle of a WAIT, then a late ack after release.
    mem_write = 1'b0; mem_read = 1'b1; dm_ctrl = 3'd0; aluout = 32'h500;
    reg_write_in = 1'b1; rd_in = 5'd4; wd_in = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("mrst_req", 32'(dm_req), 32'd0);
    check_eq("mrst_stall", 32'(stall), 32'd0);
    mem_read = 1'b0; reg_write_in = 1'b0; wd_in = 32'h0000_7777;
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    check_eq("late_req", 32'(dm_req), 32'd0);
    check_eq("late_rw", 32'(wb_reg_write), 32'd0);
    check_eq("late_wd", wb_wd, 32'h0000_7777);
    check_eq("late_stall", 32'(stall), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      c = 3'($urandom_range(0, 4));
      case ($urandom_range(0, 2))
        0: do_nonmem(1'($urandom), 5'($urandom), 2'($urandom), $urandom, 1'($urandom));
        default: begin
          wr  = 1'($urandom);
          rdq = wr ? 1'($urandom) : 1'b1;
          d   = $urandom_range(0, 20);
          if (d > 17) d = TIMEOUT;
          else if (d > 5) d = $urandom_range(0, 3);
          do_mem(wr, rdq, c, $urandom, $urandom, 1'($urandom), 5'($urandom),
                 2'($urandom), $urandom, d, $urandom);
        end
      endcase
    end

    mem_write = 1'b0; mem_read = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
